// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared ASCII constants, sizes and parser state type
package ascii_pkg;
   localparam int NUM_DIGITS = 8;
   localparam int VALUE_W    = 27;
   localparam int CNT_W      = $clog2(NUM_DIGITS);

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } parser_state_t;
endpackage

// File: rtl/ascii_dec_parser_if.sv
// rtl/ascii_dec_parser_if.sv - word-in / result-out handshake bundle for the parser
interface ascii_dec_parser_if;
   import ascii_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [8*NUM_DIGITS-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [VALUE_W-1:0]      out_value;
   logic                    out_error;
   logic [CNT_W-1:0]        out_err_pos;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_value, out_error, out_err_pos
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_value, out_error, out_err_pos
   );
endinterface

// File: rtl/ascii_digit_decode.sv
// rtl/ascii_digit_decode.sv - classifies one ASCII character and yields its digit value
module ascii_digit_decode
   import ascii_pkg::*;
(
   input  logic [7:0] char,
   output logic [3:0] digit,
   output logic       is_digit
);
   assign is_digit = (char >= ASCII_ZERO) && (char <= ASCII_NINE);
   // For '0'..'9' the low nibble already equals c - 0x30.
   assign digit    = is_digit ? char[3:0] : 4'd0;
endmodule

// File: rtl/ascii_dec_parser.sv
// rtl/ascii_dec_parser.sv - sequential 8-char ASCII decimal to binary converter
module ascii_dec_parser
   import ascii_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   ascii_dec_parser_if.slave  bus
);
   parser_state_t           state;
   logic [8*NUM_DIGITS-1:0] shreg;
   logic [VALUE_W-1:0]      acc;
   logic [VALUE_W-1:0]      acc_next;
   logic [CNT_W-1:0]        cnt;
   logic                    err;
   logic                    err_next;
   logic [CNT_W-1:0]        err_pos;
   logic [CNT_W-1:0]        err_pos_next;
   logic [3:0]              digit;
   logic                    is_digit;

   ascii_digit_decode u_decode (
      .char     (shreg[8*NUM_DIGITS-1 -: 8]),
      .digit    (digit),
      .is_digit (is_digit)
   );

   // Bad characters contribute 0, so one shift-add form covers both cases.
   assign acc_next     = (acc << 3) + (acc << 1) + VALUE_W'(digit);
   assign err_next     = err | ~is_digit;
   assign err_pos_next = (!err && !is_digit) ? cnt : err_pos;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         shreg           <= '0;
         acc             <= '0;
         cnt             <= '0;
         err             <= 1'b0;
         err_pos         <= '0;
         bus.in_ready    <= 1'b1;
         bus.out_valid   <= 1'b0;
         bus.out_value   <= '0;
         bus.out_error   <= 1'b0;
         bus.out_err_pos <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg        <= bus.in_data;
                  acc          <= '0;
                  cnt          <= '0;
                  err          <= 1'b0;
                  err_pos      <= '0;
                  bus.in_ready <= 1'b0;
                  state        <= CONV;
               end
            end
            CONV: begin
               acc     <= acc_next;
               shreg   <= shreg << 8;
               cnt     <= cnt + 1'b1;
               err     <= err_next;
               err_pos <= err_pos_next;
               if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
                  bus.out_valid   <= 1'b1;
                  bus.out_value   <= err_next ? '0 : acc_next;
                  bus.out_error   <= err_next;
                  bus.out_err_pos <= err_pos_next;
                  state           <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ascii_dec_parser.sv
// tb/tb_ascii_dec_parser.sv - directed and random checks of ascii_dec_parser against a decimal model
module tb_ascii_dec_parser;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   ascii_dec_parser_if bus ();

   ascii_dec_parser dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Value of the string as a decimal number: sum of digit * 10^(place).
   task automatic model(input logic [63:0] w, output logic [26:0] v,
                        output logic e, output logic [2:0] p);
      longint total;
      logic [7:0] b;
      total = 0;
      e = 1'b0;
      p = 3'd0;
      for (int i = 0; i < 8; i++) begin
         b = w[63 - 8*i -: 8];
         if (b >= 8'd48 && b <= 8'd57)
            total += longint'(b - 8'd48) * (10 ** (7 - i));
         else if (!e) begin
            e = 1'b1;
            p = 3'(i);
         end
      end
      v = e ? 27'd0 : 27'(total);
   endtask

   task automatic start_word(input logic [63:0] w);
      int lat;
      @(negedge clk);
      bus.in_data   = w;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      check("in_ready_idle", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("in_ready_conv", bus.in_ready, 0);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 8);
   endtask

   task automatic check_result(input logic [63:0] w);
      logic [26:0] v;
      logic        e;
      logic [2:0]  p;
      model(w, v, e, p);
      check("out_value", bus.out_value, v);
      check("out_error", bus.out_error, e);
      check("out_err_pos", bus.out_err_pos, p);
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("out_valid_after_accept", bus.out_valid, 0);
      check("in_ready_after_accept", bus.in_ready, 1);
   endtask

   task automatic run_word(input logic [63:0] w);
      start_word(w);
      check_result(w);
      release_result();
   endtask

   initial begin
      logic [63:0] w;
      logic [26:0] held_v;
      logic        held_e;
      logic [2:0]  held_p;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_value", bus.out_value, 0);
      check("rst_out_error", bus.out_error, 0);
      check("rst_out_err_pos", bus.out_err_pos, 0);
      reset_n = 1'b1;

      run_word("00000000");
      run_word("12345678");
      check("value_12345678_const", bus.out_value, 27'hBC614E);
      run_word("99999999");
      check("value_99999999_const", bus.out_value, 27'h5F5E0FF);
      run_word("12A45:78");
      check("err_pos_const", bus.out_err_pos, 3'd2);

      // Backpressure: result must hold while a new word is offered and ignored.
      start_word("55555555");
      check_result("55555555");
      held_v = bus.out_value;
      held_e = bus.out_error;
      held_p = bus.out_err_pos;
      bus.in_data  = "99999999";
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_value_stable", bus.out_value, held_v);
         check("bp_error_stable", bus.out_error, held_e);
         check("bp_pos_stable", bus.out_err_pos, held_p);
      end
      bus.in_valid = 1'b0;
      release_result();
      run_word("00000001");
      check("b2b_first", bus.out_value, 27'd1);
      run_word("00000002");
      check("b2b_second", bus.out_value, 27'd2);

      // Reset during the 4th conversion cycle.
      @(negedge clk);
      bus.in_data  = "87654321";
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_out_value", bus.out_value, 0);
      check("midrst_out_error", bus.out_error, 0);
      check("midrst_out_err_pos", bus.out_err_pos, 0);
      reset_n = 1'b1;
      run_word("00000042");
      check("after_rst_42", bus.out_value, 27'd42);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) != 0)
               w = {w[55:0], 8'h30 + 8'($urandom_range(0, 9))};
            else
               w = {w[55:0], 8'($urandom_range(0, 255))};
         end
         run_word(w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Sequential decoder that converts an 8-character packed ASCII decimal string into a binary value. It is the consumer-side counterpart of the lab's ASCII decimal test-data generator. It accepts one 64-bit word per valid/ready handshake and processes one digit per clock, most significant character first. It returns the binary value with an error flag and the position of the first non-digit character. It sits between the test-data source (or UART receive buffer) and any arithmetic or compare logic that needs binary operands.

## Interface
- NUM_DIGITS, 8, number of ASCII characters per input word
- VALUE_W, 27, output width; must satisfy 10^NUM_DIGITS − 1 < 2^VALUE_W
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  reset, synchronous, active-low
- in_valid  input  1  in_data holds a word to convert
- in_ready  output  1  block can accept a word; high only in IDLE
- in_data  input  8*NUM_DIGITS  packed ASCII; bits [63:56] = leftmost (most significant) character
- out_valid  output  1  result available; held until accepted
- out_ready  input  1  downstream accepts the result
- out_value  output  VALUE_W  binary value of the string; 0 when out_error=1
- out_error  output  1  at least one character outside "0".."9" (0x30–0x39)
- out_err_pos  output  3  index of the first bad character, 0 = leftmost; 0 when out_error=0

## Operation
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into a shift register, clear the accumulator, clear the digit counter, clear the error flag and position, go to CONV.
- CONV: each cycle, take the top 8 bits of the shift register as char c.
  - Digit case (0x30 ≤ c ≤ 0x39): acc ← (acc<<3) + (acc<<1) + (c − 0x30).
  - Non-digit case: acc ← acc*10 + 0. If the error flag is not yet set, set it and record the counter value as err_pos. Later bad characters do not change err_pos.
  - Shift the register left 8 bits and increment the counter.
  - After NUM_DIGITS digits, go to DONE.
- DONE:
  - out_valid=1.
  - out_value = error ? 0 : acc.
  - On out_ready, go to IDLE.
- Conversion always takes exactly NUM_DIGITS cycles, whether or not an error occurs. There is no early exit.
- in_valid while not in IDLE is ignored; the upstream holds the word because in_ready=0.
- Arithmetic is unsigned, done at VALUE_W bits. No overflow is possible for valid input, and none is checked.
- Reset values (on any reset_n=0 edge, including mid-CONV or in DONE):
  - State goes to IDLE; the in-flight word is discarded.
  - out_valid=0, out_value=0, out_error=0, out_err_pos=0.
  - Accumulator, counter and shift register are cleared.
  - in_ready=1 from the first cycle after reset.

## Timing
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Handshake accepted at edge k:
  - CONV occupies edges k+1..k+NUM_DIGITS.
  - out_valid is high after edge k+NUM_DIGITS, which is 8 cycles of latency.
- out_value, out_error and out_err_pos are stable for the whole time out_valid=1.
- Result accepted at edge m: in_ready is high after edge m. The next word can be accepted at edge m+1.
- Sustained throughput: one word per NUM_DIGITS+2 cycles.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.

## Structure
- Shared package ascii_pkg holds:
  - ASCII_ZERO (8'h30) and ASCII_NINE (8'h39)
  - NUM_DIGITS and VALUE_W defaults
  - the parser state enum (IDLE/CONV/DONE)
- The team's testdata generator should also use ASCII_ZERO and ASCII_NINE from ascii_pkg.
- One combinational sub-module, ascii_digit_decode:
  - input: char[7:0]
  - outputs: digit[3:0] (0 when invalid) and is_digit
- The multiply-by-10 accumulator stays inline in the parser.

## Test plan
- Reset, then "00000000" with in_valid held → accepted next edge; out_valid after 8 cycles; out_value=0, out_error=0.
- "12345678" → out_value=12345678 (0xBC614E), out_error=0, out_err_pos=0.
- "99999999" → out_value=99999999 (0x5F5E0FF); verifies full width, no truncation.
- "12A45:78" → out_error=1, out_err_pos=2, out_value=0; latency is still 8 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 → in_ready=1 the next cycle, and back-to-back words "00000001" then "00000002" produce 1 then 2.
- Assert reset_n=0 during the 4th CONV cycle of "87654321" → all outputs 0, in_ready=1. A following "00000042" yields exactly 42, with no residue from the aborted word.
